// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator for the display path feeding the Sobel
// pixel pipeline. A system-clock divider produces a one-cycle pixel strobe.
// On each strobe the x/y raster counters advance. Sync, active-video and
// line/frame strobes are decoded combinationally from the registered
// counters, so they are aligned with x/y in the same cycle.
//
// Optional build macro:
//   VGA_FRAME_CNT_EN  when defined, a 16-bit completed-frame counter is built.
//                     When undefined, frame_cnt is tied to zero.
//
// Ports:
//   clk_100MHz  in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   enable      in   1 = run, 0 = freeze divider and counters
//   p_tick      out  one-cycle pixel strobe
//   x, y        out  raster position (CW bits)
//   video_on    out  position lies inside the active area
//   hsync       out  horizontal sync, at HS_POL level while active
//   vsync       out  vertical sync, at VS_POL level while active
//   sol         out  start-of-line strobe
//   sof         out  start-of-frame strobe
//   eof         out  end-of-frame strobe
//   frame_cnt   out  completed-frame count (wraps at 16 bits)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   CLK_DIV = 4,
  parameter int   CW      = 12,
  parameter int   HD      = 640,
  parameter int   HF      = 16,
  parameter int   HR      = 96,
  parameter int   HB      = 48,
  parameter int   VD      = 480,
  parameter int   VF      = 10,
  parameter int   VR      = 2,
  parameter int   VB      = 33,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          enable,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          sol,
  output logic          sof,
  output logic          eof,
  output logic [15:0]   frame_cnt
);

  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;

  // A one-bit divider still exists for CLK_DIV=1; it simply never leaves 0.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(HT - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(VT - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(HD);
  localparam logic [CW-1:0] V_ACT    = CW'(VD);
  localparam logic [CW-1:0] HS_BEG   = CW'(HD + HF);
  localparam logic [CW-1:0] HS_END   = CW'(HD + HF + HR - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(VD + VF);
  localparam logic [CW-1:0] VS_END   = CW'(VD + VF + VR - 1);

  // Elaboration-time guards: the last raster position must be representable.
  if (longint'(HT - 1) >= (longint'(1) << CW)) begin : g_bad_cw_h
    $error("vga_timing_gen: HT-1 (%0d) does not fit in CW=%0d bits", HT - 1, CW);
  end
  if (longint'(VT - 1) >= (longint'(1) << CW)) begin : g_bad_cw_v
    $error("vga_timing_gen: VT-1 (%0d) does not fit in CW=%0d bits", VT - 1, CW);
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV (%0d) must be at least 1", CLK_DIV);
  end

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;

  logic w_run;
  logic w_div_last;
  logic w_tick;
  logic w_x_last;
  logic w_y_last;
  logic w_x_zero;
  logic w_y_zero;
  logic w_hs_act;
  logic w_vs_act;
  logic w_active;
  logic w_eof;

  // The counters are already cleared while reset is high, but the decoded
  // strobes would otherwise follow enable. Gating them with reset keeps every
  // output at its reset value for the whole reset window, including when
  // CLK_DIV=1 makes the divider compare permanently true.
  assign w_run      = enable & ~reset;
  assign w_div_last = (r_div == DIV_LAST);
  assign w_tick     = w_run & w_div_last;

  assign w_x_last   = (r_x == X_LAST);
  assign w_y_last   = (r_y == Y_LAST);
  assign w_x_zero   = (r_x == '0);
  assign w_y_zero   = (r_y == '0);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (enable) begin
      r_div <= w_div_last ? '0 : r_div + DW'(1);
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_tick) begin
      r_x <= w_x_last ? '0 : r_x + CW'(1);
      if (w_x_last) begin
        r_y <= w_y_last ? '0 : r_y + CW'(1);
      end
    end
  end

  // Interval order along each axis is display, front porch, sync, back porch.
  assign w_hs_act = (r_x >= HS_BEG) && (r_x <= HS_END);
  assign w_vs_act = (r_y >= VS_BEG) && (r_y <= VS_END);
  assign w_active = (r_x < H_ACT) && (r_y < V_ACT);
  assign w_eof    = w_tick & w_x_last & w_y_last;

  assign p_tick   = w_tick;
  assign x        = r_x;
  assign y        = r_y;
  assign video_on = w_active & w_run;
  assign hsync    = w_hs_act ? HS_POL : ~HS_POL;
  assign vsync    = w_vs_act ? VS_POL : ~VS_POL;
  assign sol      = w_tick & w_x_zero;
  assign sof      = w_tick & w_x_zero & w_y_zero;
  assign eof      = w_eof;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_eof) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

`ifdef VGA_FRAME_CNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  logic enable;

  // Instance A: small raster, CLK_DIV=3, active-low syncs.
  // HT = 8+2+3+2 = 15, VT = 4+1+2+1 = 8; hsync x=10..12, vsync y=5..6.
  logic        pa, va, hsa, vsa, sola, sofa, eofa;
  logic [5:0]  xa, ya;
  logic [15:0] fca;

  // Instance B: CLK_DIV=1, active-high syncs.
  // HT = 14, VT = 7; hsync x=10..11, vsync y=5; 98 pixels per frame.
  logic        pb, vb, hsb, vsb, solb, sofb, eofb;
  logic [3:0]  xb, yb;
  logic [15:0] fcb;

  vga_timing_gen #(
    .CLK_DIV(3), .CW(6),
    .HD(8), .HF(2), .HR(3), .HB(2),
    .VD(4), .VF(1), .VR(2), .VB(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_a (
    .clk_100MHz(clk), .reset(reset), .enable(enable),
    .p_tick(pa), .x(xa), .y(ya), .video_on(va),
    .hsync(hsa), .vsync(vsa), .sol(sola), .sof(sofa), .eof(eofa),
    .frame_cnt(fca)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .CW(4),
    .HD(8), .HF(2), .HR(2), .HB(2),
    .VD(4), .VF(1), .VR(1), .VB(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_b (
    .clk_100MHz(clk), .reset(reset), .enable(enable),
    .p_tick(pb), .x(xb), .y(yb), .video_on(vb),
    .hsync(hsb), .vsync(vsb), .sol(solb), .sof(sofb), .eof(eofb),
    .frame_cnt(fcb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst;
    logic en;
    int   n;      // clock edges to run after applying inputs (0 = settle only)
    int   x;
    int   y;
    bit   p;
    bit   vid;
    bit   hs;
    bit   vs;
    bit   sol;
    bit   sof;
    bit   eof;
    int   fc;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  initial begin
    int edges;
    int pos, ex, ey;
    int e_x, e_y, e_p, e_hs, e_vs, e_vid, e_sol, e_sof, e_eof;
    int c_p, c_sof, c_eof, c_vid;
    int bx, by;
    int b_x, b_y, b_p, b_hs, b_vs, b_vid, b_sof, b_eof;
    int cb_sof, cb_eof;

    // Instance A, cumulative edge count k after reset release in comments.
    //          rst en  n    x  y  p vid hs vs sol sof eof fc
    vec[0]  = '{1, 1, 2,    0, 0, 0, 0,  1, 1, 0,  0,  0,  0};
    vec[1]  = '{0, 1, 1,    0, 0, 0, 1,  1, 1, 0,  0,  0,  0}; // k=1
    vec[2]  = '{0, 1, 1,    0, 0, 1, 1,  1, 1, 1,  1,  0,  0}; // k=2 first tick
    vec[3]  = '{0, 1, 1,    1, 0, 0, 1,  1, 1, 0,  0,  0,  0}; // k=3
    vec[4]  = '{0, 1, 26,   9, 0, 1, 0,  1, 1, 0,  0,  0,  0}; // k=29 front porch
    vec[5]  = '{0, 1, 3,   10, 0, 1, 0,  0, 1, 0,  0,  0,  0}; // k=32 hsync start
    vec[6]  = '{0, 1, 6,   12, 0, 1, 0,  0, 1, 0,  0,  0,  0}; // k=38 hsync end
    vec[7]  = '{0, 1, 3,   13, 0, 1, 0,  1, 1, 0,  0,  0,  0}; // k=41 back porch
    vec[8]  = '{0, 1, 6,    0, 1, 1, 1,  1, 1, 1,  0,  0,  0}; // k=47 line 1
    vec[9]  = '{0, 1, 180,  0, 5, 1, 0,  1, 0, 1,  0,  0,  0}; // k=227 vsync
    vec[10] = '{0, 1, 132, 14, 7, 1, 0,  1, 1, 0,  0,  1,  0}; // k=359 eof
    vec[11] = '{0, 1, 1,    0, 0, 0, 1,  1, 1, 0,  0,  0,  1}; // k=360 wrap
    vec[12] = '{0, 0, 0,    0, 0, 0, 0,  1, 1, 0,  0,  0,  1}; // freeze
    vec[13] = '{0, 0, 5,    0, 0, 0, 0,  1, 1, 0,  0,  0,  1};
    vec[14] = '{0, 1, 0,    0, 0, 0, 1,  1, 1, 0,  0,  0,  1};
    vec[15] = '{0, 1, 2,    0, 0, 1, 1,  1, 1, 1,  1,  0,  1}; // tick at (0,0)
    vec[16] = '{0, 0, 0,    0, 0, 0, 0,  1, 1, 0,  0,  0,  1}; // drop while ticking
    vec[17] = '{0, 0, 37,   0, 0, 0, 0,  1, 1, 0,  0,  0,  1};
    vec[18] = '{0, 1, 0,    0, 0, 1, 1,  1, 1, 1,  1,  0,  1}; // resumes same pixel
    vec[19] = '{0, 1, 1,    1, 0, 0, 1,  1, 1, 0,  0,  0,  1}; // advances to x=1

    reset  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < NV; i++) begin
      reset  = vec[i].rst;
      enable = vec[i].en;
      if (vec[i].n == 0) begin
        #1;
      end else begin
        repeat (vec[i].n) @(posedge clk);
        #1;
      end
      chk($sformatf("v%0d.x", i),        64'(xa),   64'(vec[i].x));
      chk($sformatf("v%0d.y", i),        64'(ya),   64'(vec[i].y));
      chk($sformatf("v%0d.p_tick", i),   64'(pa),   64'(vec[i].p));
      chk($sformatf("v%0d.video_on", i), 64'(va),   64'(vec[i].vid));
      chk($sformatf("v%0d.hsync", i),    64'(hsa),  64'(vec[i].hs));
      chk($sformatf("v%0d.vsync", i),    64'(vsa),  64'(vec[i].vs));
      chk($sformatf("v%0d.sol", i),      64'(sola), 64'(vec[i].sol));
      chk($sformatf("v%0d.sof", i),      64'(sofa), 64'(vec[i].sof));
      chk($sformatf("v%0d.eof", i),      64'(eofa), 64'(vec[i].eof));
      chk($sformatf("v%0d.frame_cnt", i), 64'(fca), FC_ON ? 64'(vec[i].fc) : 64'd0);
    end

    // Asynchronous reset mid-line, not aligned to a clock edge.
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst.x_a",     64'(xa),   64'd0);
    chk("arst.y_a",     64'(ya),   64'd0);
    chk("arst.hsync_a", 64'(hsa),  64'd1);
    chk("arst.vsync_a", 64'(vsa),  64'd1);
    chk("arst.p_a",     64'(pa),   64'd0);
    chk("arst.vid_a",   64'(va),   64'd0);
    chk("arst.strb_a",  64'({sola, sofa, eofa}), 64'd0);
    chk("arst.fc_a",    64'(fca),  64'd0);
    chk("arst.hsync_b", 64'(hsb),  64'd0);
    chk("arst.vsync_b", 64'(vsb),  64'd0);
    chk("arst.p_b",     64'(pb),   64'd0);
    chk("arst.strb_b",  64'({solb, sofb, eofb}), 64'd0);

    // First pixel advance after release comes CLK_DIV (=3) edges later.
    @(posedge clk);
    #1 reset = 1'b0;
    edges = 0;
    while (xa == 6'd0 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("arst.first_advance_edges", 64'(edges), 64'd3);

    // Two full frames of instance A (720 edges), which also covers
    // more than seven frames of instance B.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    e_x = 0; e_y = 0; e_p = 0; e_hs = 0; e_vs = 0; e_vid = 0;
    e_sol = 0; e_sof = 0; e_eof = 0;
    c_p = 0; c_sof = 0; c_eof = 0; c_vid = 0;
    b_x = 0; b_y = 0; b_p = 0; b_hs = 0; b_vs = 0; b_vid = 0;
    b_sof = 0; b_eof = 0; cb_sof = 0; cb_eof = 0;
    for (int k = 1; k <= 720; k++) begin
      @(posedge clk);
      #1;
      pos = k / 3;
      ex  = pos % 15;
      ey  = (pos / 15) % 8;
      if (xa != 6'(ex)) e_x++;
      if (ya != 6'(ey)) e_y++;
      if (pa != ((k % 3) == 2)) e_p++;
      if (hsa != !(ex >= 10 && ex <= 12)) e_hs++;
      if (vsa != !(ey >= 5 && ey <= 6)) e_vs++;
      if (va != (ex < 8 && ey < 4)) e_vid++;
      if (sola != (pa && ex == 0)) e_sol++;
      if (sofa != (pa && ex == 0 && ey == 0)) e_sof++;
      if (eofa != (pa && ex == 14 && ey == 7)) e_eof++;
      if (pa) c_p++;
      if (sofa) c_sof++;
      if (eofa) c_eof++;
      if (pa && va) c_vid++;

      bx = k % 14;
      by = (k / 14) % 7;
      if (xb != 4'(bx)) b_x++;
      if (yb != 4'(by)) b_y++;
      if (pb != 1'b1) b_p++;
      if (hsb != (bx >= 10 && bx <= 11)) b_hs++;
      if (vsb != (by == 5)) b_vs++;
      if (vb != (bx < 8 && by < 4)) b_vid++;
      if (sofb != (bx == 0 && by == 0)) b_sof++;
      if (eofb != (bx == 13 && by == 6)) b_eof++;
      if (sofb) cb_sof++;
      if (eofb) cb_eof++;
    end

    chk("frm_a.x_errors",     64'(e_x),   64'd0);
    chk("frm_a.y_errors",     64'(e_y),   64'd0);
    chk("frm_a.ptick_errors", 64'(e_p),   64'd0);
    chk("frm_a.hsync_errors", 64'(e_hs),  64'd0);
    chk("frm_a.vsync_errors", 64'(e_vs),  64'd0);
    chk("frm_a.video_errors", 64'(e_vid), 64'd0);
    chk("frm_a.sol_errors",   64'(e_sol), 64'd0);
    chk("frm_a.sof_errors",   64'(e_sof), 64'd0);
    chk("frm_a.eof_errors",   64'(e_eof), 64'd0);
    chk("frm_a.ptick_count",  64'(c_p),   64'd240);
    chk("frm_a.sof_count",    64'(c_sof), 64'd2);
    chk("frm_a.eof_count",    64'(c_eof), 64'd2);
    chk("frm_a.video_ticks",  64'(c_vid), 64'd64);
    chk("frm_a.frame_cnt",    64'(fca),   FC_ON ? 64'd2 : 64'd0);

    chk("frm_b.x_errors",     64'(b_x),   64'd0);
    chk("frm_b.y_errors",     64'(b_y),   64'd0);
    chk("frm_b.ptick_errors", 64'(b_p),   64'd0);
    chk("frm_b.hsync_errors", 64'(b_hs),  64'd0);
    chk("frm_b.vsync_errors", 64'(b_vs),  64'd0);
    chk("frm_b.video_errors", 64'(b_vid), 64'd0);
    chk("frm_b.sof_errors",   64'(b_sof), 64'd0);
    chk("frm_b.eof_errors",   64'(b_eof), 64'd0);
    chk("frm_b.sof_count",    64'(cb_sof), 64'd7);
    chk("frm_b.eof_count",    64'(cb_eof), 64'd7);
    chk("frm_b.frame_cnt",    64'(fcb),   FC_ON ? 64'd7 : 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator. It is the successor to the fixed 640x480 controller in the display path that feeds the Sobel pixel pipeline.
- Generalises the pixel-clock divide ratio, all horizontal/vertical timing fields, sync polarity and counter width.
- Adds a run/freeze enable, line/frame strobes and a frame counter.
- Downstream pixel fetch and edge-filter logic consume x/y, video_on and the strobes.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1; 1 means p_tick is constantly high)
CW, 12, width of x/y counters
HD, 640, horizontal active pixels
HF, 16, horizontal front porch
HR, 96, horizontal sync width
HB, 48, horizontal back porch
VD, 480, vertical active lines
VF, 10, vertical front porch
VR, 2, vertical sync width
VB, 33, vertical back porch
HS_POL, 0, active level of hsync (0 = active-low)
VS_POL, 0, active level of vsync (0 = active-low)

Ports:
clk_100MHz  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = run; 0 = freeze divider and counters
p_tick  out  1  one-cycle pixel strobe
x  out  CW  horizontal position, 0..HT-1 (HT = HD+HF+HR+HB)
y  out  CW  vertical position, 0..VT-1 (VT = VD+VF+VR+VB)
video_on  out  1  position is inside the active area
hsync  out  1  horizontal sync at HS_POL level while active
vsync  out  1  vertical sync at VS_POL level while active
sol  out  1  start-of-line strobe
sof  out  1  start-of-frame strobe
eof  out  1  end-of-frame strobe
frame_cnt  out  16  completed-frame count

Behaviour:
- Reset values:
  - div counter, x, y, frame_cnt = 0.
  - video_on, sol, sof, eof, p_tick = 0.
  - hsync = ~HS_POL; vsync = ~VS_POL.
- Divider:
  - div counts 0..CLK_DIV-1 while enable=1, wraps to 0.
  - p_tick = enable & (div == CLK_DIV-1), decoded from the registered div.
- Counters advance only on clock edges where p_tick=1. This differs from the previous controller, where counters advanced every system clock.
  - x: x==HT-1 -> 0, else x+1.
  - y: changes only when x wraps. y==VT-1 -> 0, else y+1.
- Interval ordering: display, front porch, sync, back porch.
  - hsync active for HD+HF <= x <= HD+HF+HR-1.
  - vsync active for VD+VF <= y <= VD+VF+VR-1.
  - video_on = (x<HD) & (y<VD) & enable.
- hsync, vsync and video_on are combinational decodes of registered counters, so they are aligned with x/y in the same cycle. Latency from counter update to decode is zero.
- Strobes are single-cycle and qualified by p_tick, so each is high for exactly one clock per event:
  - sol = p_tick & (x==0).
  - sof = p_tick & (x==0) & (y==0).
  - eof = p_tick & (x==HT-1) & (y==VT-1).
- frame_cnt:
  - Increments on the eof clock edge.
  - Wraps 0xFFFF -> 0.
- Enable:
  - enable=0 holds div, x, y and frame_cnt; p_tick=0.
  - video_on forced 0; hsync/vsync keep their decoded levels.
  - Re-asserting enable resumes from the held position with no lost or duplicated pixel.
- Reset mid-frame returns everything to reset values immediately. The first p_tick after release occurs CLK_DIV clocks later. Position (0,0) is held until that tick.
- Elaboration-time guard: HT-1 and VT-1 must fit in CW bits; otherwise elaboration reports an error.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined: frame_cnt behaves as above.
- Undefined: the frame_cnt register is not built; the port is tied to 16'd0. All other behaviour is unchanged.

Test Plan:
- Defaults, run 2 frames -> p_tick every 4th clock; x wraps 799->0, y wraps 524->0; eof once per 420000 p_ticks; frame_cnt = 2 with VGA_FRAME_CNT_EN, 0 without.
- Defaults -> hsync low exactly for x=656..751, vsync low for y=490..491; video_on high only for x<640 and y<480; 307200 video_on p_ticks per frame.
- CLK_DIV=1, HD=8, HF=2, HR=2, HB=2, VD=4, VF=1, VR=1, VB=1, HS_POL=VS_POL=1 -> p_tick constantly high; HT=14, VT=7; hsync high for x=10..11; sof once every 98 clocks.
- Drop enable at x=100, y=50 for 37 clocks -> x, y and div frozen; video_on=0; no strobes. Re-raise -> next p_tick advances x to 101.
- Assert reset at x=300, y=200 asynchronously (not clock-aligned) -> x=y=0, hsync=vsync high (inactive, defaults) and strobes low in the same cycle. After release, the first p_tick is at clock 4.
- Bench with CW=9 and defaults -> elaboration error (799 exceeds 511).
